// File: rtl/mvm_sched.sv
// mvm_sched: sparsity-aware sequencer for the mvm matrix-vector datapath.
// Loads an activation vector, records its non-zero mask, then for each weight
// row clears the accumulator, issues only non-zero columns and hands off the
// row result.
module mvm_sched #(
    parameter int VEC_LEN = 8,
    parameter int ROWS    = 4,
    parameter int DATA_W  = 8,
    localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              acc_clr,
    output logic              mac_en,
    output logic [RW-1:0]     mac_row,
    output logic [CW-1:0]     mac_col,
    output logic [DATA_W-1:0] mac_act,
    output logic              out_valid,
    output logic [RW-1:0]     out_row,
    input  logic              out_ready,
    output logic              vec_done,
    output logic [15:0]       skip_total
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CLR   = 2'd1,
        ISSUE = 2'd2,
        EMIT  = 2'd3
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       load_idx_q;
    logic [RW-1:0]       row_q;
    logic [CW-1:0]       col_q;
    logic [VEC_LEN-1:0]  mask_q;
    logic [DATA_W-1:0]   vec_q [VEC_LEN];
    logic [15:0]         skip_q;

    logic [CW-1:0]       first_col_d;
    logic                has_first_d;
    logic [CW-1:0]       next_col_d;
    logic                has_next_d;
    logic [16:0]         skip_sum_d;
    logic [15:0]         skip_d;

    // Lowest set mask bit, and lowest set mask bit strictly above col_q
    // (scanning downwards so the lowest match is the one that sticks).
    always_comb begin
        first_col_d = '0;
        has_first_d = 1'b0;
        next_col_d  = '0;
        has_next_d  = 1'b0;
        for (int unsigned i = VEC_LEN; i > 0; i--) begin
            if (mask_q[i-1]) begin
                first_col_d = CW'(i - 1);
                has_first_d = 1'b1;
                if (CW'(i - 1) > col_q) begin
                    next_col_d = CW'(i - 1);
                    has_next_d = 1'b1;
                end
            end
        end
    end

    // Skipped-slot accumulation for one row, clamped at 16'hFFFF.
    always_comb begin
        skip_sum_d = {1'b0, skip_q} + 17'(VEC_LEN) - 17'($countones(mask_q));
        skip_d     = skip_sum_d[16] ? 16'hFFFF : skip_sum_d[15:0];
    end

    // Sequencer state: load, per-row clear/issue/emit, skip accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            load_idx_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
            mask_q     <= '0;
            skip_q     <= '0;
            for (int unsigned i = 0; i < VEC_LEN; i++) begin
                vec_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        vec_q[load_idx_q]  <= in_data;
                        mask_q[load_idx_q] <= (in_data != '0);
                        if (load_idx_q == CW'(VEC_LEN - 1)) begin
                            load_idx_q <= '0;
                            row_q      <= '0;
                            state_q    <= CLR;
                        end else begin
                            load_idx_q <= load_idx_q + CW'(1);
                        end
                    end
                end
                CLR: begin
                    col_q   <= first_col_d;
                    skip_q  <= skip_d;
                    state_q <= has_first_d ? ISSUE : EMIT;
                end
                ISSUE: begin
                    if (has_next_d) begin
                        col_q <= next_col_d;
                    end else begin
                        col_q   <= '0;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (row_q == RW'(ROWS - 1)) begin
                            row_q   <= '0;
                            mask_q  <= '0;
                            state_q <= LOAD;
                        end else begin
                            row_q   <= row_q + RW'(1);
                            state_q <= CLR;
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    // Output decode from registered state; datapath fields are zeroed when idle.
    // vec_done qualifies the final EMIT with out_ready so it coincides with
    // the accepting handshake rather than trailing it by a cycle.
    always_comb begin
        in_ready   = (state_q == LOAD);
        acc_clr    = (state_q == CLR);
        mac_en     = (state_q == ISSUE);
        mac_row    = (state_q == ISSUE) ? row_q : '0;
        mac_col    = (state_q == ISSUE) ? col_q : '0;
        mac_act    = (state_q == ISSUE) ? vec_q[col_q] : '0;
        out_valid  = (state_q == EMIT);
        out_row    = (state_q == EMIT) ? row_q : '0;
        vec_done   = (state_q == EMIT) && out_ready && (row_q == RW'(ROWS - 1));
        skip_total = skip_q;
    end

endmodule

// File: tb/tb_mvm_sched.sv
// Directed self-checking bench for mvm_sched (VEC_LEN=8, ROWS=4, DATA_W=8).
module tb_mvm_sched;

    localparam int VEC_LEN = 8;
    localparam int ROWS    = 4;
    localparam int DATA_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              acc_clr;
    logic              mac_en;
    logic [1:0]        mac_row;
    logic [2:0]        mac_col;
    logic [DATA_W-1:0] mac_act;
    logic              out_valid;
    logic [1:0]        out_row;
    logic              out_ready;
    logic              vec_done;
    logic [15:0]       skip_total;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    int ld[$];
    int exp_cols[$];
    int exp_acts[$];

    always #5 clk = ~clk;

    mvm_sched #(.VEC_LEN(VEC_LEN), .ROWS(ROWS), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .acc_clr    (acc_clr),
        .mac_en     (mac_en),
        .mac_row    (mac_row),
        .mac_col    (mac_col),
        .mac_act    (mac_act),
        .out_valid  (out_valid),
        .out_row    (out_row),
        .out_ready  (out_ready),
        .vec_done   (vec_done),
        .skip_total (skip_total)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input int ir, input int ac, input int me,
                        input int mr, input int mc, input int ma,
                        input int ov, input int orow, input int vd);
        chk({tag, " in_ready"},  32'(in_ready),  ir);
        chk({tag, " acc_clr"},   32'(acc_clr),   ac);
        chk({tag, " mac_en"},    32'(mac_en),    me);
        chk({tag, " mac_row"},   32'(mac_row),   mr);
        chk({tag, " mac_col"},   32'(mac_col),   mc);
        chk({tag, " mac_act"},   32'(mac_act),   ma);
        chk({tag, " out_valid"}, 32'(out_valid), ov);
        chk({tag, " out_row"},   32'(out_row),   orow);
        chk({tag, " vec_done"},  32'(vec_done),  vd);
    endtask

    // Entered at a negedge while LOAD; optional idle cycle before element gap_at.
    task automatic load_vec(input int gap_at);
        for (int i = 0; i < ld.size(); i++) begin
            if (i == gap_at) begin
                in_valid = 1'b0;
                #1 chk($sformatf("gap ready %0d", i), 32'(in_ready), 1);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = DATA_W'(ld[i]);
            #1 chk($sformatf("load ready %0d", i), 32'(in_ready), 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Entered at the negedge where CLR should be visible; leaves at the negedge
    // after the row's final EMIT cycle.
    task automatic run_row(input int row, input int last, input int stall);
        #1 outs($sformatf("clr r%0d", row), 0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < exp_cols.size(); k++) begin
            @(negedge clk);
            #1 outs($sformatf("mac r%0d k%0d", row, k), 0, 0, 1, row,
                    exp_cols[k], exp_acts[k], 0, 0, 0);
        end
        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            out_ready = (s == stall);
            #1 outs($sformatf("emit r%0d s%0d", row, s), 0, 0, 0, 0, 0, 0, 1, row,
                    (last != 0 && s == stall) ? 1 : 0);
        end
        @(negedge clk);
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 64 && !seen; c++) begin
            @(negedge clk);
            if (vec_done) seen = 1'b1;
        end
    endtask

    initial begin
        bit seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state
        #12;
        outs("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset skip", 32'(skip_total), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sparse vector with a gap in the input stream
        ld = '{3, 0, 0, 5, 0, 0, 0, 7};
        load_vec(4);
        exp_cols = '{0, 3, 7};
        exp_acts = '{3, 5, 7};
        for (int r = 0; r < ROWS; r++) run_row(r, (r == ROWS - 1) ? 1 : 0, 0);
        #1 chk("sparse ready after", 32'(in_ready), 1);
        chk("sparse skip", 32'(skip_total), 20);
        chk("sparse done cleared", 32'(vec_done), 0);

        // All-zero vector: each row is CLR then EMIT
        @(negedge clk);
        ld = '{0, 0, 0, 0, 0, 0, 0, 0};
        load_vec(-1);
        exp_cols.delete();
        exp_acts.delete();
        for (int r = 0; r < ROWS; r++) run_row(r, (r == ROWS - 1) ? 1 : 0, 0);
        #1 chk("zero skip", 32'(skip_total), 52);

        // Dense vector 1..8
        @(negedge clk);
        ld = '{1, 2, 3, 4, 5, 6, 7, 8};
        load_vec(-1);
        exp_cols = '{0, 1, 2, 3, 4, 5, 6, 7};
        exp_acts = '{1, 2, 3, 4, 5, 6, 7, 8};
        for (int r = 0; r < ROWS; r++) run_row(r, (r == ROWS - 1) ? 1 : 0, 0);
        #1 chk("dense skip", 32'(skip_total), 52);

        // Back-pressure on row 1 while in_valid is held high with junk data
        @(negedge clk);
        ld = '{0, 0, 9, 0, 0, 0, 0, 4};
        load_vec(-1);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        exp_cols = '{2, 7};
        exp_acts = '{9, 4};
        run_row(0, 0, 0);
        run_row(1, 0, 3);
        run_row(2, 0, 0);
        in_valid = 1'b0;
        in_data  = '0;
        run_row(3, 1, 0);
        #1 chk("bp skip", 32'(skip_total), 76);
        chk("bp ready after", 32'(in_ready), 1);

        // Asynchronous reset during ISSUE of row 2
        @(negedge clk);
        ld = '{1, 2, 3, 4, 5, 6, 7, 8};
        load_vec(-1);
        exp_cols = '{0, 1, 2, 3, 4, 5, 6, 7};
        exp_acts = '{1, 2, 3, 4, 5, 6, 7, 8};
        run_row(0, 0, 0);
        run_row(1, 0, 0);
        #1 outs("rst clr r2", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1 outs("rst mac r2", 0, 0, 1, 2, 0, 1, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1 outs("async reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("async reset skip", 32'(skip_total), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 outs("post reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        ld = '{0, 6, 0, 0, 0, 0, 0, 0};
        load_vec(-1);
        exp_cols = '{1};
        exp_acts = '{6};
        for (int r = 0; r < ROWS; r++) run_row(r, (r == ROWS - 1) ? 1 : 0, 0);
        #1 chk("fresh skip", 32'(skip_total), 28);

        // Saturation: stream all-zero vectors, 32 skipped slots each
        in_valid = 1'b1;
        in_data  = '0;
        for (int n = 1; n <= 2049; n++) begin
            wait_done(seen);
            if (!seen) begin
                chk($sformatf("sat vec_done n%0d", n), 32'(seen), 1);
                break;
            end
            if (n == 2046) chk("sat 2046", 32'(skip_total), 65500);
            if (n == 2047) chk("sat 2047", 32'(skip_total), 65532);
            if (n == 2048) chk("sat 2048", 32'(skip_total), 65535);
            if (n == 2049) chk("sat 2049", 32'(skip_total), 65535);
        end
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
